// File: rtl/shift_reg_unit.sv
// shift_reg_unit: sequential 32-bit shift/rotate unit feeding the RegShift write-back input.
//
// Ports:
//   clk      rising-edge system clock
//   reset    synchronous, active-high reset
//   start    request pulse, accepted only when not busy (IDLE or DONE)
//   op       000 pass, 001 sll, 010 srl, 011 sra, 100 rotl, 101 rotr, 110/111 pass
//   data_in  operand, latched on an accepted start
//   shamt    shift amount, latched on an accepted start
//   result   registered shift result, valid from done until the next accepted start
//   busy     high while an iterative operation is in progress
//   done     one-cycle pulse marking result valid
//
// Build option: define SHIFT_REG_UNIT_BARREL_EN to compute the whole shift in a single barrel
// stage at the accepted-start edge. In that mode done always follows one cycle after start and
// busy never asserts. Without it, the unit shifts one bit position per clock.
module shift_reg_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        accept;

  // A start is only honoured outside SHIFT; nothing is queued.
  assign accept = start && (state_q != StShift);

  assign result = result_q;
  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);

`ifdef SHIFT_REG_UNIT_BARREL_EN

  // Rotates use a doubled operand so that shamt=0 needs no special case.
  function automatic logic [31:0] barrel(input logic [31:0] v, input logic [2:0] o,
                                         input logic [4:0] s);
    logic [63:0] rot;
    rot = '0;
    case (o)
      3'b001:  barrel = v << s;
      3'b010:  barrel = v >> s;
      3'b011:  barrel = $unsigned($signed(v) >>> s);
      3'b100: begin
        rot    = {v, v} << s;
        barrel = rot[63:32];
      end
      3'b101: begin
        rot    = {v, v} >> s;
        barrel = rot[31:0];
      end
      default: barrel = v;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (accept) begin
      result_d = barrel(data_in, op, shamt);
      state_d  = StDone;
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

`else

  logic [2:0] op_q, op_d;
  logic [4:0] cnt_q, cnt_d;

  function automatic logic [31:0] step1(input logic [31:0] v, input logic [2:0] o);
    case (o)
      3'b001:  step1 = {v[30:0], 1'b0};
      3'b010:  step1 = {1'b0, v[31:1]};
      3'b011:  step1 = {v[31], v[31:1]};
      3'b100:  step1 = {v[30:0], v[31]};
      3'b101:  step1 = {v[0], v[31:1]};
      default: step1 = v;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    case (state_q)
      StShift: begin
        // Pass ops still count down so every op has the same latency.
        result_d = step1(result_q, op_q);
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = StDone;
      end
      default: begin
        if (accept) begin
          result_d = data_in;
          op_d     = op;
          cnt_d    = shamt;
          state_d  = (shamt == 5'd0) ? StDone : StShift;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      op_q     <= 3'b000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

`endif

endmodule

// File: tb/tb_shift_reg_unit.sv
// Testbench for shift_reg_unit; works in both the iterative and barrel builds.
module tb_shift_reg_unit;

`ifdef SHIFT_REG_UNIT_BARREL_EN
  localparam bit Barrel = 1'b1;
`else
  localparam bit Barrel = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  shift_reg_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic [4:0] s);
    return Barrel ? 1 : int'(s) + 1;
  endfunction

  // Reference: apply the single-bit operation s times.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d,
                                        input logic [4:0] s);
    logic [31:0] v;
    v = d;
    for (int i = 0; i < int'(s); i++) begin
      case (o)
        3'b001:  v = v << 1;
        3'b010:  v = v >> 1;
        3'b011:  v = {v[31], v[31:1]};
        3'b100:  v = {v[30:0], v[31]};
        3'b101:  v = {v[0], v[31:1]};
        default: v = v;
      endcase
    end
    return v;
  endfunction

  task automatic pop_compare(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected done, result=%08h with empty scoreboard", name, result);
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        failures++;
        $display("FAIL %s: result=%08h expected=%08h", name, result, e);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; op = 3'b001; data_in = 32'hFFFF_FFFF; shamt = 5'd3;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 32'h0) begin
      failures++; $display("FAIL reset_result: result=%08h expected=00000000", result);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: busy=%b expected=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: done=%b expected=0", done); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_dominates_start: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  // Issue one op, then watch busy each cycle and check done latency and result.
  // intrude>0 drives an ignored start (data FFFFFFFF) in cycle N+intrude+1 while shifting.
  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] e, input string name, input int intrude);
    int lat;
    bit got;
    lat = lat_of(s);
    got = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(e);
    start = 1'b1; op = o; data_in = d; shamt = s;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (intrude != 0 && k == intrude && !Barrel) begin
        start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd1;
      end
      @(negedge clk);
      checks++;
      if (busy !== (k < lat)) begin
        failures++;
        $display("FAIL %s_busy: cycle N+%0d busy=%b expected=%b", name, k, busy, (k < lat));
      end
      if (done === 1'b1) begin
        checks++;
        if (k != lat) begin
          failures++;
          $display("FAIL %s_latency: done at N+%0d expected N+%0d", name, k, lat);
        end
        pop_compare(name);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected at N+%0d", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_plan_ops();
    run_op(3'b001, 32'h0000_0001, 5'd4,  32'h0000_0010, "sll4",      0);
    run_op(3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31",     0);
    run_op(3'b010, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl31",     0);
    run_op(3'b010, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "shamt0",    0);
    run_op(3'b101, 32'h0000_0001, 5'd1,  32'h8000_0000, "rotr1",     0);
    run_op(3'b100, 32'h8000_0001, 5'd4,  32'h0000_0018, "rotl4",     0);
    run_op(3'b110, 32'h1234_5678, 5'd5,  32'h1234_5678, "pass110",   0);
    run_op(3'b000, 32'hCAFE_F00D, 5'd2,  32'hCAFE_F00D, "pass000",   0);
  endtask

  task automatic test_ignored_start();
    run_op(3'b001, 32'h0000_0001, 5'd8, 32'h0000_0100, "ignore_start", 2);
  endtask

  task automatic test_back_to_back();
    int l1, l3;
    bit exp_done;
    l1 = lat_of(5'd2);
    l3 = lat_of(5'd1);
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    start = 1'b1; op = 3'b001; data_in = 32'h0000_0001; shamt = 5'd2;
    for (int c = 1; c <= l1 + l3 + 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == l1) begin
        exp_q.push_back(32'h0000_00A5);
        start = 1'b1; op = 3'b010; data_in = 32'h0000_00A5; shamt = 5'd0;
      end else if (c == l1 + 1) begin
        exp_q.push_back(32'h8000_0000);
        start = 1'b1; op = 3'b101; data_in = 32'h0000_0001; shamt = 5'd1;
      end
      @(negedge clk);
      exp_done = (c == l1) || (c == l1 + 1) || (c == l1 + 1 + l3);
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done: cycle %0d done=%b expected=%b", c, done, exp_done);
      end
      if (done === 1'b1) pop_compare("b2b_result");
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_reset_midway();
    bit exp_done;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b001; data_in = 32'h0000_0001; shamt = 5'd10;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      reset = (k == 3);
      @(negedge clk);
      if (k == 4) begin
        checks++;
        if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL abort_state: result=%08h busy=%b done=%b expected 00000000 0 0",
                   result, busy, done);
        end
      end else begin
        exp_done = Barrel && (k == 1);
        checks++;
        if (done !== exp_done) begin
          failures++;
          $display("FAIL abort_done: cycle N+%0d done=%b expected=%b", k, done, exp_done);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] d;
    logic [4:0]  s;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      run_op(o, d, s, model(o, d, s), "random", 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000; data_in = '0; shamt = '0;
    test_reset();
    test_plan_ops();
    test_ignored_start();
    test_back_to_back();
    test_reset_midway();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
